// File: rtl/pixel_writer.sv
// Pixel stream consumer: two-stage capture/address pipeline feeding a write-command
// FIFO drained to the memory arbiter. Optional clipping under `PIXEL_WRITER_CLIP_EN.
module pixel_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pixel_data_rdy,
    input  logic [11:0]       X_coord,
    input  logic [11:0]       Y_coord,
    input  logic [7:0]        color,
    input  logic              line_complete,
    input  logic [ADDR_W-1:0] dest_base,
    input  logic [11:0]       dest_width,
    input  logic [11:0]       max_x,
    input  logic [11:0]       max_y,
    output logic              ena_pause,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    input  logic              mem_wr_ack,
    output logic              busy,
    output logic              done
`ifdef PIXEL_WRITER_CLIP_EN
    ,
    output logic [15:0]       clip_count
`endif
);

    // Handshake: a pixel is taken on any edge where pixel_data_rdy && enable; a memory
    // write completes on any edge where mem_wr_req && mem_wr_ack. The generator must
    // hold off while ena_pause is high.

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = PW + 2;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    // Stage 1: captured input
    logic        s1_valid;
    logic [11:0] s1_x;
    logic [11:0] s1_y;
    logic [7:0]  s1_color;

    // Stage 2: computed command
    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [7:0]        s2_color;

    // FIFO
    logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [ADDR_W+7:0] head;

    logic              line_pending;
    logic              drained;
    logic [IW-1:0]     in_flight;

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] w_ext;
    logic [ADDR_W-1:0] addr_calc;
    logic              clip_hit;

    // Signed coordinates extend so negative offsets wrap modulo 2^ADDR_W
    assign x_ext     = {{(ADDR_W-12){s1_x[11]}}, s1_x};
    assign y_ext     = {{(ADDR_W-12){s1_y[11]}}, s1_y};
    assign w_ext     = {{(ADDR_W-12){1'b0}}, dest_width};
    assign addr_calc = dest_base + y_ext * w_ext + x_ext;

`ifdef PIXEL_WRITER_CLIP_EN
    assign clip_hit = s1_x[11] || s1_y[11] || (s1_x >= max_x) || (s1_y >= max_y);
`else
    logic unused_clip;
    assign clip_hit    = 1'b0;
    assign unused_clip = ^{max_x, max_y};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_color <= '0;
        end else if (enable) begin
            s1_valid <= pixel_data_rdy;
            if (pixel_data_rdy) begin
                s1_x     <= X_coord;
                s1_y     <= Y_coord;
                s1_color <= color;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_color <= '0;
        end else if (enable) begin
            s2_valid <= s1_valid && !clip_hit;
            s2_addr  <= addr_calc;
            s2_color <= s1_color;
        end
    end

`ifdef PIXEL_WRITER_CLIP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_count <= '0;
        end else if (enable && s1_valid && clip_hit && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign pop        = !fifo_empty && mem_wr_ack;
    // A push into a full FIFO only lands when the head leaves on the same edge
    assign push       = enable && s2_valid && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s2_addr, s2_color};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign drained = line_pending && !s1_valid && !s2_valid && fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_pending <= 1'b0;
        end else if (line_complete) begin
            line_pending <= 1'b1;
        end else if (drained) begin
            line_pending <= 1'b0;
        end
    end

    // Counts only registered occupancy; a pop this cycle is deliberately not credited
    assign in_flight = IW'(count) + IW'(s1_valid) + IW'(s2_valid);
    assign ena_pause = reset && (!enable || (in_flight >= IW'(FIFO_DEPTH)));

    assign mem_wr_req  = !fifo_empty;
    assign mem_address = fifo_empty ? '0 : head[ADDR_W+7:8];
    assign mem_data    = fifo_empty ? '0 : head[7:0];
    assign busy        = line_pending || s1_valid || s2_valid || !fifo_empty;
    assign done        = drained;

endmodule

// File: tb/tb_pixel_writer.sv
// Randomised scoreboard bench for pixel_writer: stimulus pushes expected writes,
// a monitor pops and compares every accepted memory write and every done pulse.
module tb_pixel_writer;

    localparam int DEPTH = 8;
    localparam int AW    = 20;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          pixel_data_rdy;
    logic [11:0]   X_coord;
    logic [11:0]   Y_coord;
    logic [7:0]    color;
    logic          line_complete;
    logic [AW-1:0] dest_base;
    logic [11:0]   dest_width;
    logic [11:0]   max_x;
    logic [11:0]   max_y;
    logic          ena_pause;
    logic          mem_wr_req;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_wr_ack;
    logic          busy;
    logic          done;
`ifdef PIXEL_WRITER_CLIP_EN
    logic [15:0]   clip_count;
`endif

    logic [AW+7:0] exp_q[$];
    int n_checks;
    int n_fail;
    int done_seen;
    int ack_mode;
    int exp_clips;

    pixel_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pixel_data_rdy(pixel_data_rdy), .X_coord(X_coord), .Y_coord(Y_coord),
        .color(color), .line_complete(line_complete), .dest_base(dest_base),
        .dest_width(dest_width), .max_x(max_x), .max_y(max_y),
        .ena_pause(ena_pause), .mem_wr_req(mem_wr_req), .mem_address(mem_address),
        .mem_data(mem_data), .mem_wr_ack(mem_wr_ack), .busy(busy), .done(done)
`ifdef PIXEL_WRITER_CLIP_EN
        , .clip_count(clip_count)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: byte address as plain modular arithmetic
    function automatic logic [AW-1:0] model_addr(input int x, input int y);
        int a;
        a = int'(dest_base) + y * int'(dest_width) + x;
        return a[AW-1:0];
    endfunction

    function automatic bit model_clipped(input int x, input int y);
`ifdef PIXEL_WRITER_CLIP_EN
        return (x < 0) || (y < 0) || (x >= int'(max_x)) || (y >= int'(max_y));
`else
        return (x != x) || (y != y);
`endif
    endfunction

    // Driver tasks
    task automatic send_pixel(input int x, input int y, input logic [7:0] c);
        int g;
        logic [31:0] xv;
        logic [31:0] yv;
        g = 0;
        while (ena_pause && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (ena_pause) begin
            n_checks++;
            n_fail++;
            $display("FAIL pause_timeout: ena_pause still 1 after %0d cycles, required 0", g);
            return;
        end
        xv = x;
        yv = y;
        X_coord        = xv[11:0];
        Y_coord        = yv[11:0];
        color          = c;
        pixel_data_rdy = 1'b1;
        if (model_clipped(x, y)) exp_clips++;
        else exp_q.push_back({model_addr(x, y), c});
        @(negedge clk);
        pixel_data_rdy = 1'b0;
    endtask

    task automatic pulse_line();
        line_complete = 1'b1;
        @(negedge clk);
        line_complete = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check(name, {30'd0, exp_q.size() != 0, busy}, 32'd0);
    endtask

    // Arbiter model: ack policy selected by ack_mode (0 hold off, 1 always, 2 random)
    initial begin
        mem_wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_mode == 1) mem_wr_ack = 1'b1;
            else if (ack_mode == 2) mem_wr_ack = 1'($urandom_range(0, 1));
            else mem_wr_ack = 1'b0;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [AW+7:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                if (mem_wr_req && mem_wr_ack) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none",
                                 mem_address, mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_cmd", {4'd0, mem_address, mem_data}, {4'd0, e});
                    end
                end
                if (done) begin
                    done_seen++;
                    check("done_after_writes", exp_q.size(), 32'd0);
                end
            end
        end
    end

    initial begin
        #3ms;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int d0;
        int x;
        int y;
        logic [11:0] r;
        n_checks = 0; n_fail = 0; done_seen = 0; exp_clips = 0; ack_mode = 1;
        reset = 1'b0; enable = 1'b1; pixel_data_rdy = 1'b0; line_complete = 1'b0;
        X_coord = '0; Y_coord = '0; color = '0;
        dest_base = '0; dest_width = 12'd640; max_x = 12'd640; max_y = 12'd480;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req", mem_wr_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pause", ena_pause, 0);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_data, 0);
`ifdef PIXEL_WRITER_CLIP_EN
        check("rst_clip_count", clip_count, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Short horizontal run with immediate acks
        dest_base = 20'h01000; dest_width = 12'd640; ack_mode = 1;
        d0 = done_seen;
        for (int i = 10; i <= 13; i++) send_pixel(i, 5, 8'(i * 3 + 1));
        pulse_line();
        drain("t1_drain");
        check("t1_done_count", done_seen - d0, 1);

        // Back-pressure: fill with acks withheld, then release
        ack_mode = 0;
        for (int i = 0; i < 7; i++) send_pixel(i, 2, 8'($urandom));
        repeat (3) @(negedge clk);
        check("t2_pause_at_7", ena_pause, 0);
        send_pixel(7, 2, 8'($urandom));
        check("t2_pause_at_8", ena_pause, 1);
        check("t2_req_held", mem_wr_req, 1);
        ack_mode = 2;
        for (int i = 8; i < 20; i++) send_pixel(i, 2, 8'($urandom));
        drain("t2_drain");

`ifdef PIXEL_WRITER_CLIP_EN
        dest_base = '0; dest_width = 12'd640; max_x = 12'd640; max_y = 12'd480;
        ack_mode = 1;
        d0 = int'(clip_count);
        exp_clips = 0;
        send_pixel(-1, 0, 8'h11);
        send_pixel(640, 0, 8'h22);
        send_pixel(0, 480, 8'h33);
        send_pixel(639, 479, 8'h44);
        drain("t3_drain");
        check("t3_clip_count", int'(clip_count) - d0, exp_clips);
`endif

        // Single point: latency then one done
        dest_base = 20'h00200; dest_width = 12'd100; ack_mode = 0;
        d0 = done_seen;
        send_pixel(7, 7, 8'h5A);
        #1 check("t5_req_lat1", mem_wr_req, 0);
        @(negedge clk);
        #1 check("t5_req_lat2", mem_wr_req, 0);
        @(negedge clk);
        #1 check("t5_req_lat3", mem_wr_req, 1);
        pulse_line();
        ack_mode = 1;
        drain("t5_drain");
        check("t5_done_count", done_seen - d0, 1);

        // Enable low freezes the pipeline but still latches line_complete
        d0 = done_seen;
        send_pixel(3, 4, 8'hC3);
        enable = 1'b0;
        #1 check("t7_pause_disabled", ena_pause, 1);
        pulse_line();
        repeat (4) @(negedge clk);
        check("t7_frozen_req", mem_wr_req, 0);
        check("t7_frozen_busy", busy, 1);
        check("t7_no_early_done", done_seen - d0, 0);
        enable = 1'b1;
        drain("t7_drain");
        check("t7_done_count", done_seen - d0, 1);

        // Reset with writes queued
        ack_mode = 0;
        for (int i = 0; i < 5; i++) send_pixel(i, 1, 8'($urandom));
        repeat (3) @(negedge clk);
        check("t4_req_before", mem_wr_req, 1);
        reset = 1'b0;
        #1;
        check("t4_req_async", mem_wr_req, 0);
        check("t4_busy_async", busy, 0);
        check("t4_pause_async", ena_pause, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ack_mode = 1;
        repeat (20) @(negedge clk);
        check("t4_idle_after", {31'd0, busy}, 0);

        // Address wraps modulo 2^ADDR_W
        dest_base = 20'hFFFFF; dest_width = 12'd640;
        send_pixel(1, 0, 8'h77);
        drain("t6_drain");

        // Randomised lines
        for (int r_i = 0; r_i < 4; r_i++) begin
            dest_base  = AW'($urandom_range(0, 20'hFFFFF));
            dest_width = 12'($urandom_range(1, 4095));
            max_x      = 12'($urandom_range(1, 800));
            max_y      = 12'($urandom_range(1, 600));
            ack_mode   = 2;
            d0 = done_seen;
            for (int k = 0; k < 30; k++) begin
`ifdef PIXEL_WRITER_CLIP_EN
                x = $urandom_range(0, 900) - 50;
                y = $urandom_range(0, 700) - 50;
`else
                r = 12'($urandom);
                x = int'($signed(r));
                r = 12'($urandom);
                y = int'($signed(r));
`endif
                send_pixel(x, y, 8'($urandom));
                if ($urandom_range(0, 7) == 0) @(negedge clk);
            end
            pulse_line();
            drain("rand_drain");
            check("rand_done_count", done_seen - d0, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
